clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 41 ++++
 rtl/wrap_counter.sv | 35 +++
 rtl/clock_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared state type, field limits and widths for the clock-setting controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_t;

  localparam int HH_MAX = 23;
  localparam int MS_MAX = 59;
  localparam int HH_W   = 5;
  localparam int MS_W   = 6;

  // Blank bit of the field being edited, ordered {hh, mm, ss}.
  function automatic logic [2:0] fieldMask(input state_t st);
    logic [2:0] mask;
    mask = 3'b000;
    case (st)
      ST_SET_HH: mask = 3'b100;
      ST_SET_MM: mask = 3'b010;
      ST_SET_SS: mask = 3'b001;
      default:   mask = 3'b000;
    endcase
    return mask;
  endfunction

  function automatic state_t nextMode(input state_t st);
    state_t nxt;
    nxt = ST_RUN;
    case (st)
      ST_RUN:    nxt = ST_SET_HH;
      ST_SET_HH: nxt = ST_SET_MM;
      ST_SET_MM: nxt = ST_SET_SS;
      default:   nxt = ST_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter for one time field; carry flags an increment past MAX.
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         load_zero,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] r_value;
  logic         w_atMax;
  logic         w_atZero;

  assign w_atMax  = (r_value == W'(MAX));
  assign w_atZero = (r_value == '0);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (load_zero) begin
      r_value <= '0;
    end else if (inc && !dec) begin
      r_value <= w_atMax ? '0 : r_value + W'(1);
    end else if (dec && !inc) begin
      r_value <= w_atZero ? W'(MAX) : r_value - W'(1);
    end
  end

  assign value = r_value;
  assign carry = inc && !dec && w_atMax;

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS clock with a key-driven set mode and blinking field blanking.
// Define CLOCK_SET_TIMEOUT_EN to build the idle auto-exit from edit.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_CYC = 25000000,
  parameter int TIMEOUT_S = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            key_mode,
  input  logic            key_inc,
  input  logic            key_dec,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic [1:0]      mode,
  output logic [2:0]      blank
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  state_t        r_state;
  logic [BW-1:0] r_blinkCnt;
  logic          r_hidden;
  logic [2:0]    r_blank;

  state_t        w_nextState;
  logic [BW-1:0] w_nextCnt;
  logic          w_nextHidden;
  logic          w_isRun;
  logic          w_editOk;
  logic          w_incOk;
  logic          w_decOk;
  logic          w_anyKey;
  logic          w_timeoutHit;
  logic          w_ssInc, w_ssDec, w_ssCarry;
  logic          w_mmInc, w_mmDec, w_mmCarry;
  logic          w_hhInc, w_hhDec;

  assign w_isRun  = (r_state == ST_RUN);
  assign w_anyKey = key_mode | key_inc | key_dec;
  // A mode press wins over inc/dec; inc together with dec is ignored.
  assign w_editOk = !w_isRun && !key_mode && (key_inc ^ key_dec);
  assign w_incOk  = w_editOk && key_inc;
  assign w_decOk  = w_editOk && key_dec;

  // Seconds come from tick_1hz directly, so there is no sub-second phase to carry across edits.
  assign w_ssInc = (w_isRun && tick_1hz) || ((r_state == ST_SET_SS) && w_incOk);
  assign w_ssDec = (r_state == ST_SET_SS) && w_decOk;
  assign w_mmInc = (w_isRun && w_ssCarry) || ((r_state == ST_SET_MM) && w_incOk);
  assign w_mmDec = (r_state == ST_SET_MM) && w_decOk;
  assign w_hhInc = (w_isRun && w_mmCarry) || ((r_state == ST_SET_HH) && w_incOk);
  assign w_hhDec = (r_state == ST_SET_HH) && w_decOk;

  wrap_counter #(.MAX(MS_MAX), .W(MS_W)) u_ss (
    .clk       (clk),
    .load_zero (rst),
    .inc       (w_ssInc),
    .dec       (w_ssDec),
    .value     (ss),
    .carry     (w_ssCarry)
  );

  wrap_counter #(.MAX(MS_MAX), .W(MS_W)) u_mm (
    .clk       (clk),
    .load_zero (rst),
    .inc       (w_mmInc),
    .dec       (w_mmDec),
    .value     (mm),
    .carry     (w_mmCarry)
  );

  wrap_counter #(.MAX(HH_MAX), .W(HH_W)) u_hh (
    .clk       (clk),
    .load_zero (rst),
    .inc       (w_hhInc),
    .dec       (w_hhDec),
    .value     (hh),
    .carry     ()
  );

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);

  logic [TW-1:0] r_idleSecs;

  assign w_timeoutHit = !w_isRun && !w_anyKey && tick_1hz &&
                        (r_idleSecs == TW'(TIMEOUT_S - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idleSecs <= '0;
    end else if (w_isRun || w_anyKey || w_timeoutHit) begin
      r_idleSecs <= '0;
    end else if (tick_1hz) begin
      r_idleSecs <= r_idleSecs + TW'(1);
    end
  end
`else
  assign w_timeoutHit = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    if (key_mode) begin
      w_nextState = nextMode(r_state);
    end else if (w_timeoutHit) begin
      w_nextState = ST_RUN;
    end
  end

  // Blink restarts visible on any state change or accepted edit.
  always_comb begin
    w_nextCnt    = r_blinkCnt;
    w_nextHidden = r_hidden;
    if ((w_nextState == ST_RUN) || (w_nextState != r_state) || w_incOk || w_decOk) begin
      w_nextCnt    = '0;
      w_nextHidden = 1'b0;
    end else if (r_blinkCnt == BW'(BLINK_CYC - 1)) begin
      w_nextCnt    = '0;
      w_nextHidden = !r_hidden;
    end else begin
      w_nextCnt    = r_blinkCnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_blinkCnt <= '0;
      r_hidden   <= 1'b0;
      r_blank    <= 3'b000;
    end else begin
      r_state    <= w_nextState;
      r_blinkCnt <= w_nextCnt;
      r_hidden   <= w_nextHidden;
      r_blank    <= w_nextHidden ? fieldMask(w_nextState) : 3'b000;
    end
  end

  assign mode  = r_state;
  assign blank = r_blank;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with BLINK_CYC=4 and TIMEOUT_S=3.
// Timeout checks follow CLOCK_SET_TIMEOUT_EN.
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic [1:0] mode;
  logic [2:0] blank;

  int vecCount = 0;
  int errCount = 0;

  clock_set_ctrl #(.BLINK_CYC(4), .TIMEOUT_S(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .key_dec  (key_dec),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .mode     (mode),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, ".hh"}, int'(hh), h);
    checkOutput({tag, ".mm"}, int'(mm), m);
    checkOutput({tag, ".ss"}, int'(ss), s);
  endtask

  // One clock of stimulus, set up at the falling edge, released 1ns after the rising edge.
  task automatic applyStimulus(input logic doRst, input logic tick, input logic kMode,
                               input logic kInc, input logic kDec);
    @(negedge clk);
    rst      = doRst;
    tick_1hz = tick;
    key_mode = kMode;
    key_inc  = kInc;
    key_dec  = kDec;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tick_1hz = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressMode();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pressInc();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pressDec();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;

    // Reset overrides a tick and keys in the same cycle
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkTime("reset", 0, 0, 0);
    checkOutput("reset.mode", int'(mode), 0);
    checkOutput("reset.blank", int'(blank), 0);

    tick();
    checkTime("runTick", 0, 0, 1);
    pressInc();
    checkTime("runIncIgnored", 0, 0, 1);
    checkOutput("runIncIgnored.mode", int'(mode), 0);

    // Edit wrap and preload of 23:59:58
    pressMode();
    checkOutput("enterSetHh", int'(mode), 1);
    pressDec();
    checkOutput("hhDecWrap", int'(hh), 23);
    pressMode();
    checkOutput("enterSetMm", int'(mode), 2);
    pressDec();
    checkOutput("mmDecWrap", int'(mm), 59);
    pressInc();
    checkTime("mmIncWrap", 23, 0, 1);
    pressDec();
    pressMode();
    checkOutput("enterSetSs", int'(mode), 3);
    repeat (3) pressDec();
    checkTime("preload", 23, 59, 58);
    pressMode();
    checkOutput("backToRun", int'(mode), 0);

    // Rollover
    tick();
    checkTime("roll1", 23, 59, 59);
    checkOutput("roll1.mode", int'(mode), 0);
    tick();
    checkTime("roll2", 0, 0, 0);
    checkOutput("roll2.mode", int'(mode), 0);

    // Freeze in SET_MM
    tick();
    tick();
    pressMode();
    pressMode();
    repeat (5) tick();
    checkTime("frozen", 0, 0, 2);
    checkOutput("frozen.mode", int'(mode), 2);
    pressMode();
    pressMode();
    checkOutput("resume.mode", int'(mode), 0);
    tick();
    checkTime("resume", 0, 0, 3);

    // Key conflicts
    pressMode();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("incDecConflict", int'(hh), 0);
    pressInc();
    checkOutput("hhInc", int'(hh), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("modeIncConflict.mode", int'(mode), 2);
    checkOutput("modeIncConflict.hh", int'(hh), 1);

    // Blink in SET_SS, half-period of 4 cycles
    pressMode();
    checkOutput("blinkEntry.mode", int'(mode), 3);
    checkOutput("blinkEntry", int'(blank), 0);
    idle(3);
    checkOutput("blinkVis3", int'(blank), 0);
    idle(1);
    checkOutput("blinkHid4", int'(blank), 1);
    idle(3);
    checkOutput("blinkHid7", int'(blank), 1);
    idle(1);
    checkOutput("blinkVis8", int'(blank), 0);
    idle(4);
    checkOutput("blinkHid12", int'(blank), 1);
    pressInc();
    checkOutput("blinkRestart", int'(blank), 0);
    checkOutput("blinkRestart.ss", int'(ss), 4);
    idle(3);
    checkOutput("blinkRestartVis", int'(blank), 0);
    idle(1);
    checkOutput("blinkRestartHid", int'(blank), 1);

    // Reset mid-edit in SET_MM
    pressMode();
    pressMode();
    pressMode();
    pressInc();
    checkOutput("preReset.mm", int'(mm), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("midReset.mode", int'(mode), 0);
    checkTime("midReset", 0, 0, 0);
    checkOutput("midReset.blank", int'(blank), 0);

    // Idle ticks in SET_HH
    pressMode();
    idle(4);
    checkOutput("hhBlinkMask", int'(blank), 4);
    pressInc();
    repeat (3) tick();
`ifdef CLOCK_SET_TIMEOUT_EN
    checkOutput("timeout.mode", int'(mode), 0);
    checkTime("timeout", 1, 0, 0);
    tick();
    checkTime("afterTimeout", 1, 0, 1);
`else
    checkOutput("noTimeout.mode", int'(mode), 1);
    checkTime("noTimeout", 1, 0, 0);
    tick();
    checkOutput("stillEdit.mode", int'(mode), 1);
    checkTime("stillEdit", 1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
